// File: rtl/mem_wb_dmem_stage.sv
// MEM/WB boundary stage: owns the data-cache handshake, stalls upstream while a
// request is outstanding, and aligns/extends load data for WB.
// Optional misalignment check: define MEM_MISALIGN_CHK_EN.
module mem_wb_dmem_stage #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MEM_valid_i,
  input  logic             MEM_mem_read_i,
  input  logic             MEM_mem_write_i,
  input  logic [width-1:0] MEM_data_mem_address_i,
  input  logic [width-1:0] MEM_data_mem_wdata_i,
  input  logic [3:0]       MEM_mem_byte_en_i,
  input  logic [2:0]       MEM_funct3_i,
  input  logic [width-1:0] MEM_alu_out_i,
  input  logic [width-1:0] MEM_pc_plus4_i,
  input  logic [4:0]       MEM_rd_i,
  input  logic             MEM_load_regfile_i,
  input  logic             MEM_halt_en_i,
  output logic             dmem_read_o,
  output logic             dmem_write_o,
  output logic [width-1:0] dmem_address_o,
  output logic [width-1:0] dmem_wdata_o,
  output logic [3:0]       dmem_mbe_o,
  input  logic [width-1:0] dmem_rdata_i,
  input  logic             dmem_resp_i,
  output logic             stall_o,
`ifdef MEM_MISALIGN_CHK_EN
  output logic             WB_misaligned_o,
`endif
  output logic             WB_valid_o,
  output logic [width-1:0] WB_load_data_o,
  output logic [width-1:0] WB_alu_out_o,
  output logic [width-1:0] WB_pc_plus4_o,
  output logic [4:0]       WB_rd_o,
  output logic             WB_load_regfile_o,
  output logic             WB_mem_read_o,
  output logic             WB_halt_en_o
);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  // request context held while the cache is busy
  logic [width-1:0] alu_q, pc_q;
  logic [4:0]       rd_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             lrf_q, halt_q, load_q;

  logic is_mem, mis, accept;
  assign is_mem = MEM_mem_read_i | MEM_mem_write_i;

`ifdef MEM_MISALIGN_CHK_EN
  assign mis = is_mem &
               (((MEM_funct3_i[1:0] == 2'b01) && MEM_data_mem_address_i[0]) ||
                ((MEM_funct3_i[1:0] == 2'b10) && (MEM_data_mem_address_i[1:0] != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  assign accept  = (state == IDLE) && MEM_valid_i && is_mem && !mis;
  assign stall_o = (state == BUSY) || accept;

  function automatic logic [width-1:0] align(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [width-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*off +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  align = {{(width-8){b[7]}}, b};
      3'b100:  align = {{(width-8){1'b0}}, b};
      3'b001:  align = {{(width-16){h[15]}}, h};
      3'b101:  align = {{(width-16){1'b0}}, h};
      default: align = d;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      dmem_read_o       <= 1'b0;
      dmem_write_o      <= 1'b0;
      dmem_address_o    <= '0;
      dmem_wdata_o      <= '0;
      dmem_mbe_o        <= '0;
      WB_valid_o        <= 1'b0;
      WB_load_data_o    <= '0;
      WB_alu_out_o      <= '0;
      WB_pc_plus4_o     <= '0;
      WB_rd_o           <= '0;
      WB_load_regfile_o <= 1'b0;
      WB_mem_read_o     <= 1'b0;
      WB_halt_en_o      <= 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
      WB_misaligned_o   <= 1'b0;
`endif
      alu_q <= '0; pc_q <= '0; rd_q <= '0; f3_q <= '0; off_q <= '0;
      lrf_q <= 1'b0; halt_q <= 1'b0; load_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
`ifdef MEM_MISALIGN_CHK_EN
          WB_misaligned_o <= MEM_valid_i && mis;
`endif
          if (accept) begin
            state          <= BUSY;
            dmem_read_o    <= MEM_mem_read_i && !MEM_mem_write_i;
            dmem_write_o   <= MEM_mem_write_i;
            dmem_address_o <= {MEM_data_mem_address_i[width-1:2], 2'b00};
            dmem_wdata_o   <= MEM_data_mem_wdata_i;
            dmem_mbe_o     <= MEM_mem_byte_en_i;
            alu_q  <= MEM_alu_out_i;
            pc_q   <= MEM_pc_plus4_i;
            rd_q   <= MEM_rd_i;
            f3_q   <= MEM_funct3_i;
            off_q  <= MEM_data_mem_address_i[1:0];
            lrf_q  <= MEM_load_regfile_i;
            halt_q <= MEM_halt_en_i;
            load_q <= MEM_mem_read_i && !MEM_mem_write_i;
            WB_valid_o        <= 1'b0;
            WB_load_regfile_o <= 1'b0;
          end else if (MEM_valid_i) begin
            // non-memory op (or misaligned op) goes straight through
            WB_valid_o        <= 1'b1;
            WB_load_data_o    <= '0;
            WB_alu_out_o      <= MEM_alu_out_i;
            WB_pc_plus4_o     <= MEM_pc_plus4_i;
            WB_rd_o           <= MEM_rd_i;
            WB_load_regfile_o <= MEM_load_regfile_i && !mis;
            WB_mem_read_o     <= MEM_mem_read_i && !MEM_mem_write_i;
            WB_halt_en_o      <= MEM_halt_en_i;
          end else begin
            WB_valid_o        <= 1'b0;
            WB_load_regfile_o <= 1'b0;
          end
        end
        BUSY: begin
          if (dmem_resp_i) begin
            state             <= IDLE;
            dmem_read_o       <= 1'b0;
            dmem_write_o      <= 1'b0;
            WB_valid_o        <= 1'b1;
            WB_load_data_o    <= load_q ? align(f3_q, off_q, dmem_rdata_i) : '0;
            WB_alu_out_o      <= alu_q;
            WB_pc_plus4_o     <= pc_q;
            WB_rd_o           <= rd_q;
            WB_load_regfile_o <= lrf_q;
            WB_mem_read_o     <= load_q;
            WB_halt_en_o      <= halt_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_wb_dmem_stage.md
Name: mem_wb_dmem_stage

Overview:
- Pipeline stage directly downstream of the MEM stage. Registers MEM results into the MEM/WB boundary for the WB stage.
- Owns the data-cache handshake: holds a load/store request until `dmem_resp`, and stalls the upstream pipeline meanwhile.
- Aligns and sign/zero-extends load data so WB receives a ready-to-write register value.

Parameters:
- width, 32, datapath width; address and data buses are `width` bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- MEM_valid_i  in  1  MEM stage presents an instruction this cycle
- MEM_mem_read_i  in  1  instruction is a load
- MEM_mem_write_i  in  1  instruction is a store
- MEM_data_mem_address_i  in  width  byte address from MEM
- MEM_data_mem_wdata_i  in  width  store data, already forwarded
- MEM_mem_byte_en_i  in  4  byte enables, already shifted by address[1:0]
- MEM_funct3_i  in  3  load size/sign select
- MEM_alu_out_i  in  width  ALU result
- MEM_pc_plus4_i  in  width  PC+4
- MEM_rd_i  in  5  destination register
- MEM_load_regfile_i  in  1  instruction writes rd
- MEM_halt_en_i  in  1  halt marker
- dmem_read_o  out  1  cache read request
- dmem_write_o  out  1  cache write request
- dmem_address_o  out  width  word-aligned address (bits [1:0] = 0)
- dmem_wdata_o  out  width  store data
- dmem_mbe_o  out  4  store byte mask
- dmem_rdata_i  in  width  cache read data
- dmem_resp_i  in  1  cache completion, one-cycle pulse
- stall_o  out  1  freeze IF..MEM pipeline registers
- WB_valid_o  out  1  WB registers hold a valid instruction
- WB_load_data_o  out  width  aligned, extended load value
- WB_alu_out_o  out  width  registered ALU result
- WB_pc_plus4_o  out  width  registered PC+4
- WB_rd_o  out  5  registered rd
- WB_load_regfile_o  out  1  registered regfile write enable, gated by WB_valid_o
- WB_mem_read_o  out  1  registered load flag; selects the load data path in WB
- WB_halt_en_o  out  1  registered halt marker

Behaviour:
- Reset:
  - On a clk edge with rst=1: FSM goes to IDLE.
  - All registered outputs go to 0: dmem_*, WB_*.
  - stall_o=0 in the following cycle.
- FSM states are IDLE and BUSY.
- IDLE, MEM_valid_i=1, no memory op (mem_read=0, mem_write=0):
  - WB registers capture the inputs at the next edge; WB_valid_o=1; WB_load_data_o=0.
  - stall_o=0. Latency is 1 cycle.
- IDLE, MEM_valid_i=1, memory op:
  - Same cycle: stall_o=1 (combinational).
  - Next edge: latch request fields, enter BUSY.
  - Register dmem_read_o/dmem_write_o=1, dmem_address_o={addr[width-1:2],2'b00}, dmem_wdata_o, dmem_mbe_o.
  - Register WB_valid_o=0 (bubble).
- Both mem_read and mem_write set: write takes priority; dmem_read_o stays 0.
- BUSY:
  - stall_o=1; request outputs held stable.
  - On dmem_resp_i=1, at the edge: drop dmem_read_o/dmem_write_o, capture dmem_rdata_i, load the WB registers with WB_valid_o=1, return to IDLE.
  - stall_o is 0 from the cycle after the response.
- Timing: accept in cycle N, response in cycle N+k (k≥1) → stall_o high cycles N..N+k, WB_valid_o high in cycle N+k+1.
- IDLE, MEM_valid_i=0: WB_valid_o=0 at the next edge.
- Load alignment uses the latched address[1:0] (byte offset b):
  - funct3 000 (lb): sign-extend byte b.
  - funct3 100 (lbu): zero-extend byte b.
  - funct3 001 (lh): sign-extend the halfword at addr[1]. funct3 101 (lhu): zero-extend it.
  - funct3 010 (lw) and any other encoding: raw word.
- Stores: WB_load_data_o=0.
- dmem_resp_i in IDLE is ignored.
- A response arriving in the same cycle as rst=1 is dropped; reset wins.
- Upstream must hold all MEM_*_i constant while stall_o=1. Inputs are sampled only in IDLE.

Optional Feature:
- Macro: MEM_MISALIGN_CHK_EN.
- Enabled: add output WB_misaligned_o (1 bit).
  - Misaligned means: a halfword access (funct3[1:0]=01) with addr[0]=1, or a word access (funct3[1:0]=10) with addr[1:0]≠0.
  - A misaligned memory op issues no dmem request, does not stall, and passes straight to WB in 1 cycle.
  - That WB cycle has WB_misaligned_o=1 and WB_load_regfile_o=0.
- Disabled: no port and no check; the word-aligned request is issued as usual.

Test Plan:
- Reset, then ADD-type (valid=1, mem_read=mem_write=0, alu_out=0x1234, rd=5) → next cycle WB_valid_o=1, WB_alu_out_o=0x1234, WB_rd_o=5, stall_o=0 throughout.
- lb, addr=0x1003, dmem_rdata=0x80FF_FF00, resp 3 cycles after the request goes up → dmem_address_o=0x1000; stall_o high for 4 cycles; WB_load_data_o=0xFFFF_FF80.
- lhu, addr=0x2002, rdata=0xBEEF_1234 → WB_load_data_o=0x0000_BEEF; lh, same rdata → 0xFFFF_BEEF.
- sw, addr=0x3000, wdata=0xDEADBEEF, mbe=0xF, resp after 1 cycle → dmem_write_o=1 for exactly 1 cycle, dmem_read_o=0, WB_load_data_o=0, WB_valid_o=1 next cycle.
- rst asserted while BUSY on a load → dmem_read_o=0 and stall_o=0 after the edge; a dmem_resp_i the following cycle is ignored, WB_valid_o stays 0.
- With MEM_MISALIGN_CHK_EN, lw at addr=0x1001 → no dmem request, stall_o=0, next cycle WB_misaligned_o=1, WB_load_regfile_o=0.
